mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit that sequences the shared datapath (ALU, PC, IR, register file, unified memory) through the fetch, decode, execute, memory and writeback steps.
- Moore FSM. Control outputs are decoded from the current state only. The exceptions are the ALU opcode, which is decoded from state plus Funct, and the branch-taken PC write, which uses the ALU Zero flag.
- Sits between the IR fields, the ALU flags and all datapath enables and muxes.

Parameters:
- OVF_SUPPRESS, 1: when 1, signed add/sub/addi with ALU overflow skip register writeback. When 0, the writeback proceeds.
- STATE_W, 4: width of the state register and of dbg_state.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, sampled at the end of the cycle
- O  in  1  ALU signed overflow flag, sampled at the end of the cycle
- PCWrite  out  1  PC load enable (unconditional, or branch taken)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  writeback data select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register select: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A register
- ALUSrcB  out  2  ALU B select: 00=B register, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- ALUCtrl  out  3  ALU opcode
- ImmZext  out  1  1 selects the zero-extended immediate (ori)
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- dbg_state  out  STATE_W  current state

Behaviour:
- ALUCtrl encoding: AND=000, OR=001, NOR=011, ADD=100, ADDU=101, SUB=110. Codes 010 and 111 are never driven.
- Reset: synchronous, on a rising edge with reset=1, state <= FETCH. While reset=1, PCWrite, MemRead, MemWrite, IRWrite and RegWrite are forced to 0. All other outputs are 0 except dbg_state=FETCH. Reset asserted mid-instruction aborts it, and no write occurs in that cycle.
- Supported opcodes:
  - R-type (Op=000000) with Funct: add=100000, addu=100001, sub=100010, and=100100, or=100101, nor=100111
  - lw=100011, sw=101011, beq=000100, j=000010, addi=001000, ori=001101
- States and actions (unlisted outputs are 0):
  - FETCH(0): MemRead, IRWrite, ALUSrcB=01, ALUCtrl=ADDU, PCWrite, PCSource=00. Next: DECODE.
  - DECODE(1): ALUSrcB=11, ALUCtrl=ADDU (branch target into ALUOut). Next by Op:
    - lw/sw -> MEMADR
    - R-type -> REXEC
    - beq -> BEQ
    - j -> JUMP
    - addi/ori -> IEXEC
    - any other Op -> FETCH (NOP, no side effects)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADDU. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): MemRead, IorD=1. Next: MEMWB.
  - MEMWB(4): RegWrite, MemtoReg=1, RegDst=0. Next: FETCH.
  - MEMWR(5): MemWrite, IorD=1. Next: FETCH.
  - REXEC(6): ALUSrcA=1, ALUSrcB=00, ALUCtrl from Funct. Unsupported Funct drives ADDU and goes to FETCH. If OVF_SUPPRESS and O=1 on add/sub, next is FETCH. Otherwise next is RWB.
  - RWB(7): RegWrite, RegDst=1. Next: FETCH.
  - BEQ(8): ALUSrcA=1, ALUSrcB=00, ALUCtrl=SUB, PCSource=01, PCWrite=Zero. Next: FETCH.
  - JUMP(9): PCWrite, PCSource=10. Next: FETCH.
  - IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADD for addi; ALUCtrl=OR with ImmZext=1 for ori. If OVF_SUPPRESS and O=1 on addi, next is FETCH. Otherwise next is IWB.
  - IWB(11): RegWrite, RegDst=0. Next: FETCH.
  - Codes 12-15 are illegal and go to FETCH on the next edge.
- Cycle counts: lw=5, sw=4, R-type=4, addi/ori=4, beq=3, j=3, unknown=2. An overflow abort takes 3 cycles.
- ImmZext is registered together with the state so it stays stable in IWB.
- Zero and O are combinational inputs. They are valid before the clock edge; the ALU settles in under 1 cycle. They are ignored outside BEQ, REXEC and IEXEC.

Decomposition:
- Shared package `mc_pkg`:
  - ALUCtrl codes AND, OR, NOR, ADD, ADDU, SUB
  - opcode and Funct constants
  - state encodings FETCH..IWB
  - ALUSrcB and PCSource encodings
- One natural sub-module, `alu_op_dec` (combinational): maps (state, Funct, Op) to ALUCtrl and ImmZext. Its table is reusable by the single-cycle core.

Test Plan:
- Reset held for 2 cycles mid-lw (in MEMRD) -> dbg_state=0; RegWrite, MemWrite and PCWrite are 0 during reset. The first cycle after release shows FETCH outputs with ALUCtrl=101.
- lw (Op=100011) -> dbg_state sequence 0,1,2,3,4,0. MEMRD has IorD=1, MemRead=1. MEMWB has RegWrite=1, MemtoReg=1.
- R add (Funct=100000) with O=0 -> REXEC ALUCtrl=100, then RWB RegWrite=1, RegDst=1. Repeat with O=1 and OVF_SUPPRESS=1 -> no RegWrite pulse, return to FETCH after REXEC. Same stimulus with addu (Funct=100001) and O=1 -> RegWrite occurs.
- beq with Zero=1 -> BEQ state has ALUCtrl=110, PCWrite=1, PCSource=01. With Zero=0 -> PCWrite=0. Both return to FETCH in 3 cycles.
- ori (Op=001101) -> IEXEC ALUCtrl=001, ImmZext=1, then IWB RegWrite=1, RegDst=0. j (Op=000010) -> JUMP PCWrite=1, PCSource=10.
- Op=111111 -> DECODE then FETCH. No MemWrite, RegWrite or branch/jump PCWrite is ever asserted; only the FETCH PC increment occurs.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, ALU opcodes,
// instruction fields and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_ADDU = 3'b101,
    ALU_SUB  = 3'b110
  } alu_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Opcode dispatch out of DECODE; unknown opcodes retire as a NOP.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t nxt;
    unique case (op)
      OP_LW, OP_SW:     nxt = S_MEMADR;
      OP_RTYPE:         nxt = S_REXEC;
      OP_BEQ:           nxt = S_BEQ;
      OP_J:             nxt = S_JUMP;
      OP_ADDI, OP_ORI:  nxt = S_IEXEC;
      default:          nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Bundle between the control unit and the datapath: IR fields and ALU flags in,
// every enable and mux select out.
interface mc_ctrl_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       O;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUCtrl;
  logic       ImmZext;
  logic [1:0] PCSource;

  modport master (
    input  Op, Funct, Zero, O,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUCtrl, ImmZext, PCSource
  );

  modport slave (
    output Op, Funct, Zero, O,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUCtrl, ImmZext, PCSource
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_op_dec.sv
// ALU opcode decode from (state, Funct, Op); also flags the signed ops whose
// overflow may cancel writeback and whether an R-type Funct is supported.
module alu_op_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_ctrl,
  output logic       imm_zext,
  output logic       funct_ok,
  output logic       ovf_check
);

  always_comb begin
    alu_ctrl  = ALU_AND;
    imm_zext  = 1'b0;
    funct_ok  = 1'b0;
    ovf_check = 1'b0;
    unique case (state)
      S_FETCH, S_DECODE, S_MEMADR: alu_ctrl = ALU_ADDU;
      S_REXEC: begin
        funct_ok = 1'b1;
        unique case (funct)
          FN_ADD:  begin alu_ctrl = ALU_ADD; ovf_check = 1'b1; end
          FN_ADDU: alu_ctrl = ALU_ADDU;
          FN_SUB:  begin alu_ctrl = ALU_SUB; ovf_check = 1'b1; end
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          default: begin alu_ctrl = ALU_ADDU; funct_ok = 1'b0; end
        endcase
      end
      S_BEQ: alu_ctrl = ALU_SUB;
      S_IEXEC: begin
        if (op == OP_ORI) begin
          alu_ctrl = ALU_OR;
          imm_zext = 1'b1;
        end else begin
          alu_ctrl  = ALU_ADD;
          ovf_check = 1'b1;
        end
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared datapath.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter bit          OVF_SUPPRESS = 1'b1,
  parameter int unsigned STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  mc_ctrl_fsm_if.master      bus,
  output logic [STATE_W-1:0] dbg_state
);

  state_t    state, state_nxt;
  logic      zext_q;
  alu_ctrl_t dec_alu;
  logic      dec_zext, dec_funct_ok, dec_ovf_check, ovf_abort;

  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, src_a, imm_zext;
  logic [1:0] src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_view;

  alu_op_dec u_alu_op_dec (
    .state    (state),
    .op       (bus.Op),
    .funct    (bus.Funct),
    .alu_ctrl (dec_alu),
    .imm_zext (dec_zext),
    .funct_ok (dec_funct_ok),
    .ovf_check(dec_ovf_check)
  );

  assign ovf_abort = OVF_SUPPRESS && dec_ovf_check && bus.O;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      zext_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Carries the ori zero-extend select from IEXEC into IWB.
      zext_q <= (state == S_IEXEC) && dec_zext && (state_nxt == S_IWB);
    end
  end

  always_comb begin
    state_nxt  = S_FETCH;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_ctrl   = dec_alu;
    imm_zext   = dec_zext | zext_q;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        src_b     = SRCB_FOUR;
        pc_write  = 1'b1;
        pc_src    = PCSRC_ALU;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        src_b     = SRCB_IMMSH2;
        state_nxt = decode_dispatch(bus.Op);
      end
      S_MEMADR: begin
        src_a     = 1'b1;
        src_b     = SRCB_IMM;
        state_nxt = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_REXEC: begin
        src_a     = 1'b1;
        src_b     = SRCB_B;
        state_nxt = (!dec_funct_ok || ovf_abort) ? S_FETCH : S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        src_a    = 1'b1;
        src_b    = SRCB_B;
        pc_src   = PCSRC_ALUOUT;
        pc_write = bus.Zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      S_IEXEC: begin
        src_a     = 1'b1;
        src_b     = SRCB_IMM;
        state_nxt = ovf_abort ? S_FETCH : S_IWB;
      end
      S_IWB: reg_write = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    // Reset takes effect combinationally so an aborted instruction writes nothing.
    if (reset) begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      src_a      = 1'b0;
      src_b      = '0;
      pc_src     = '0;
      alu_ctrl   = '0;
      imm_zext   = 1'b0;
    end
  end

  assign state_view = reset ? S_FETCH : state;
  assign dbg_state  = STATE_W'(state_view);

  assign bus.PCWrite  = pc_write;
  assign bus.IorD     = iord;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegDst   = reg_dst;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.ImmZext  = imm_zext;
  assign bus.PCSource = pc_src;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instructions and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_ctrl_fsm;

  localparam bit OVF_SUP = 1'b1;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000, T_ORI = 6'b001101;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_NOR = 6'b100111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.OVF_SUPPRESS(OVF_SUP), .STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Field order: PCWrite IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  //              ALUSrcA ALUSrcB[1:0] ALUCtrl[2:0] ImmZext PCSource[1:0]
  function automatic logic [16:0] observed();
    return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUCtrl, bus.ImmZext, bus.PCSource};
  endfunction

  function automatic logic funct_known(input logic [5:0] f);
    return (f == F_ADD) || (f == F_ADDU) || (f == F_SUB) ||
           (f == F_AND) || (f == F_OR) || (f == F_NOR);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      F_ADD:   return 3'b100;
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_NOR:   return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  // Expected datapath controls for one step of an instruction.
  function automatic logic [16:0] expect_ctrl(input int st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z);
    logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, zx;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, zx} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      0:  begin pcw = 1; mrd = 1; irw = 1; asb = 2'b01; alu = 3'b101; end
      1:  begin asb = 2'b11; alu = 3'b101; end
      2:  begin asa = 1; asb = 2'b10; alu = 3'b101; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; alu = funct_alu(fn); end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pcw = z; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; zx = (op == T_ORI); alu = zx ? 3'b001 : 3'b100; end
      11: begin rw = 1; zx = (op == T_ORI); end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, alu, zx, pcs};
  endfunction

  task automatic check_now(input logic [3:0] exp_st, input logic [16:0] exp_ctrl,
                           input string tag);
    checks++;
    assert (dbg_state === exp_st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, dbg_state, exp_st);
    end
    checks++;
    assert (observed() === exp_ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: got %b expected %b", tag, observed(), exp_ctrl);
    end
  endtask

  // Runs one instruction from FETCH; zsel/osel < 0 randomize the ALU flags per cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zsel, input int osel, input string tag);
    int   path[$];
    logic z, o;
    case (op)
      T_RTYPE:       path = funct_known(fn) ? '{0, 1, 6, 7} : '{0, 1, 6};
      T_LW:          path = '{0, 1, 2, 3, 4};
      T_SW:          path = '{0, 1, 2, 5};
      T_BEQ:         path = '{0, 1, 8};
      T_J:           path = '{0, 1, 9};
      T_ADDI, T_ORI: path = '{0, 1, 10, 11};
      default:       path = '{0, 1};
    endcase
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk);
      bus.Op    = op;
      bus.Funct = fn;
      z = (zsel < 0) ? 1'($urandom) : (zsel != 0);
      o = (osel < 0) ? 1'($urandom) : (osel != 0);
      bus.Zero = z;
      bus.O    = o;
      #1;
      check_now(4'(path[i]), expect_ctrl(path[i], op, fn, z),
                $sformatf("%s[%0d]", tag, i));
      if (OVF_SUP && o &&
          ((path[i] == 6 && (fn == F_ADD || fn == F_SUB)) ||
           (path[i] == 10 && op == T_ADDI)))
        break;
    end
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_ORI};
    fns = '{F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR};

    reset = 1'b1;
    bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.O = 1'b0;
    @(negedge clk); #1;
    check_now(4'd0, '0, "reset_init");
    @(posedge clk); #1;
    reset = 1'b0;

    // lw interrupted by reset while in MEMRD, held for two cycles
    bus.Op = T_LW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_now(4'(i), expect_ctrl(i, T_LW, '0, 1'b0), $sformatf("lw_pre_reset[%0d]", i));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_now(4'd0, '0, "reset_in_memrd");
    @(negedge clk); #1;
    check_now(4'd0, '0, "reset_hold");
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(T_LW,    '0,     -1, -1, "lw");
    run_instr(T_SW,    '0,     -1, -1, "sw");
    run_instr(T_RTYPE, F_ADD,  -1,  0, "add_o0");
    run_instr(T_RTYPE, F_ADD,  -1,  1, "add_o1");
    run_instr(T_RTYPE, F_SUB,  -1,  1, "sub_o1");
    run_instr(T_RTYPE, F_ADDU, -1,  1, "addu_o1");
    run_instr(T_RTYPE, F_NOR,  -1,  1, "nor_o1");
    run_instr(T_RTYPE, 6'b111000, -1, 0, "bad_funct");
    run_instr(T_BEQ,   '0,      1, -1, "beq_z1");
    run_instr(T_BEQ,   '0,      0, -1, "beq_z0");
    run_instr(T_ORI,   '0,     -1,  1, "ori");
    run_instr(T_ADDI,  '0,     -1,  0, "addi_o0");
    run_instr(T_ADDI,  '0,     -1,  1, "addi_o1");
    run_instr(T_J,     '0,     -1, -1, "j");
    run_instr(6'b111111, '0,   -1, -1, "unknown_op");

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 6) == 6) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, -1, -1, $sformatf("rnd%0d_op%b_fn%b", n, op, fn));
    end

    // Trailing FETCH confirms the last random instruction retired on time.
    @(negedge clk); #1;
    check_now(4'd0, expect_ctrl(0, '0, '0, 1'b0), "final_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
